// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared definitions for the gate sweep controller slice.
// Holds the FSM state encoding, the number of truth-table vectors swept,
// and the width of the per-vector dwell counter.
package gate_sweep_ctrl_pkg;

  localparam int unsigned NUM_VECS = 4;
  localparam int unsigned VEC_W    = 2;
  localparam int unsigned DWELL_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef logic [VEC_W-1:0] vec_t;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Bundle between the sweep controller and its environment.
//   start/abort/expected : sweep requests and reference truth table
//   in1/in2              : drive pins of the external 2-input gate
//   gate_out             : response of the external gate
//   busy/done/tt/pass    : sweep status and captured truth table
// master = environment side, slave = controller side.
interface gate_sweep_ctrl_if;
  import gate_sweep_ctrl_pkg::*;

  logic                start;
  logic                abort;
  logic [NUM_VECS-1:0] expected;
  logic                in1;
  logic                in2;
  logic                gate_out;
  logic                busy;
  logic                done;
  logic [NUM_VECS-1:0] tt;
  logic                pass;

  modport master (
    output start, abort, expected, gate_out,
    input  in1, in2, busy, done, tt, pass
  );

  modport slave (
    input  start, abort, expected, gate_out,
    output in1, in2, busy, done, tt, pass
  );

endinterface

// File: rtl/gate_sweep_ctrl_dwell_counter.sv
// Per-vector dwell counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : clear count to zero (start of a vector)
//   enable     : advance count by one
//   tc         : count has reached DWELL-1, i.e. this is the last dwell cycle
// Counting saturates at DWELL-1 so the counter never wraps within a vector.
module dwell_counter
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic tc
);

  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == LAST);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Truth-table sweep controller for an external 2-input gate.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gate_sweep_ctrl_if.slave (start/abort/expected in,
//                in1/in2 gate drive, gate_out response, busy/done/tt/pass)
// On start, vectors 00,01,10,11 are each held for DWELL cycles; gate_out is
// captured into tt[vec] on the last dwell cycle. A one-cycle DONE follows,
// reporting pass = (tt == expected latched at start).
module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_sweep_ctrl_if.slave  bus
);

  state_e              state_q, state_d;
  vec_t                vec_q, vec_d;
  logic [NUM_VECS-1:0] tt_q, tt_d;
  logic [NUM_VECS-1:0] exp_q, exp_d;
  logic                pass_q, pass_d;
  logic                cnt_load;
  logic                cnt_en;
  logic                cnt_tc;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    tt_d     = tt_q;
    exp_d    = exp_q;
    pass_d   = pass_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort takes priority over start while idle
        if (bus.start && !bus.abort) begin
          exp_d    = bus.expected;
          tt_d     = '0;
          pass_d   = 1'b0;
          vec_d    = '0;
          cnt_load = 1'b1;
          state_d  = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (bus.abort) begin
          vec_d    = '0;
          pass_d   = 1'b0;
          cnt_load = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_tc) begin
          tt_d[vec_q] = bus.gate_out;
          cnt_load    = 1'b1;
          if (vec_q == vec_t'(NUM_VECS - 1)) begin
            vec_d   = '0;
            // registered here so pass is already valid in the DONE cycle
            pass_d  = (tt_d == exp_q);
            state_d = ST_DONE;
          end else begin
            vec_d = vec_q + vec_t'(1);
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      tt_q    <= tt_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.busy = (state_q == ST_DRIVE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.in1  = (state_q == ST_DRIVE) & vec_q[1];
  assign bus.in2  = (state_q == ST_DRIVE) & vec_q[0];
  assign bus.tt   = tt_q;
  assign bus.pass = pass_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: one instance with DWELL=2 (index 0) and one
// with DWELL=1 (index 1), each driving its own modelled external gate.
module tb_gate_sweep_ctrl;

  localparam int G_OR   = 0;
  localparam int G_AND  = 1;
  localparam int G_ZERO = 2;
  localparam int G_XOR  = 3;
  localparam int G_TBL  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       start_r [2];
  logic       abort_r [2];
  logic [3:0] exp_r   [2];
  int         gcode   [2];
  logic [3:0] rtbl    [2];

  gate_sweep_ctrl_if bus_a ();
  gate_sweep_ctrl_if bus_b ();

  gate_sweep_ctrl #(.DWELL(2)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  gate_sweep_ctrl #(.DWELL(1)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // External gate behaviour: bit i of a truth table = output for {a,b} = i
  function automatic logic gate_fn(input int code, input logic a, input logic b,
                                   input logic [3:0] tbl);
    logic [1:0] idx;
    idx = {a, b};
    case (code)
      G_OR:    return a | b;
      G_AND:   return a & b;
      G_ZERO:  return 1'b0;
      G_XOR:   return a ^ b;
      default: return tbl[idx];
    endcase
  endfunction

  assign bus_a.start    = start_r[0];
  assign bus_a.abort    = abort_r[0];
  assign bus_a.expected = exp_r[0];
  assign bus_a.gate_out = gate_fn(gcode[0], bus_a.in1, bus_a.in2, rtbl[0]);
  assign bus_b.start    = start_r[1];
  assign bus_b.abort    = abort_r[1];
  assign bus_b.expected = exp_r[1];
  assign bus_b.gate_out = gate_fn(gcode[1], bus_b.in1, bus_b.in2, rtbl[1]);

  logic [1:0] in1_w, in2_w, busy_w, done_w, pass_w;
  logic [3:0] tt_w [2];
  assign in1_w  = {bus_b.in1,  bus_a.in1};
  assign in2_w  = {bus_b.in2,  bus_a.in2};
  assign busy_w = {bus_b.busy, bus_a.busy};
  assign done_w = {bus_b.done, bus_a.done};
  assign pass_w = {bus_b.pass, bus_a.pass};
  assign tt_w[0] = bus_a.tt;
  assign tt_w[1] = bus_b.tt;

  function automatic int dwell_of(input int s);
    return (s == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pin/status per cycle k after the start-sampling edge:
  // vector v is driven in cycles v*d+1 .. (v+1)*d, done in cycle 4d+1.
  // abort high during cycle a (a <= 4d) makes every later cycle idle.
  task automatic run_sweep(input int s, input int gate, input logic [3:0] tbl,
                           input logic [3:0] expv, input int abort_at,
                           input int restart_at, input bit exp_chg,
                           output logic [3:0] tt_o, output logic pass_o);
    int d;
    bit aborted;
    logic [3:0] pins_exp;
    int v;
    d = dwell_of(s);
    aborted = (abort_at != 0) && (abort_at <= 4*d);
    gcode[s] = gate;
    rtbl[s] = tbl;
    exp_r[s] = expv;
    start_r[s] = 1'b1;
    tick();
    start_r[s] = 1'b0;
    for (int k = 1; k <= 4*d + 2; k++) begin
      if (aborted && k > abort_at) begin
        pins_exp = 4'b0000;
      end else if (k <= 4*d) begin
        v = (k - 1) / d;
        pins_exp = {v[1], v[0], 1'b1, 1'b0};
      end else if (k == 4*d + 1) begin
        pins_exp = 4'b0001;
      end else begin
        pins_exp = 4'b0000;
      end
      chk($sformatf("s%0d_k%0d_in1_in2_busy_done", s, k),
          32'({in1_w[s], in2_w[s], busy_w[s], done_w[s]}), 32'(pins_exp));
      abort_r[s] = (k == abort_at);
      start_r[s] = (k == restart_at);
      if (exp_chg && k == 2) exp_r[s] = ~expv;
      tick();
    end
    abort_r[s] = 1'b0;
    start_r[s] = 1'b0;
    tt_o = tt_w[s];
    pass_o = pass_w[s];
  endtask

  typedef struct {
    int         sel;
    int         gate;
    logic [3:0] expv;
    int         abort_at;
    int         restart_at;
    bit         exp_chg;
    logic [3:0] tt_exp;
    bit         pass_exp;
  } vec_rec_t;

  vec_rec_t vecs [11];

  initial begin
    logic [3:0] tt_a, tt_prev;
    logic       pass_a;

    vecs[0]  = '{0, G_OR,   4'b1110, 0, 0, 1'b1, 4'b1110, 1'b1};
    vecs[1]  = '{1, G_AND,  4'b1110, 0, 0, 1'b0, 4'b1000, 1'b0};
    vecs[2]  = '{0, G_ZERO, 4'b1110, 0, 0, 1'b0, 4'b0000, 1'b0};
    vecs[3]  = '{1, G_ZERO, 4'b1110, 0, 0, 1'b0, 4'b0000, 1'b0};
    vecs[4]  = '{0, G_OR,   4'b1110, 0, 3, 1'b0, 4'b1110, 1'b1};
    vecs[5]  = '{0, G_OR,   4'b1110, 3, 0, 1'b0, 4'b0000, 1'b0};
    vecs[6]  = '{0, G_OR,   4'b1110, 0, 0, 1'b0, 4'b1110, 1'b1};
    vecs[7]  = '{0, G_XOR,  4'b0110, 0, 9, 1'b1, 4'b0110, 1'b1};
    vecs[8]  = '{1, G_AND,  4'b1000, 0, 0, 1'b1, 4'b1000, 1'b1};
    vecs[9]  = '{1, G_OR,   4'b1110, 4, 0, 1'b0, 4'b0110, 1'b0};
    vecs[10] = '{0, G_OR,   4'b1110, 9, 0, 1'b0, 4'b1110, 1'b1};

    for (int s = 0; s < 2; s++) begin
      start_r[s] = 1'b0;
      abort_r[s] = 1'b0;
      exp_r[s]   = 4'b0000;
      gcode[s]   = G_OR;
      rtbl[s]    = 4'b0000;
    end

    // reset state
    #12;
    for (int s = 0; s < 2; s++)
      chk($sformatf("s%0d_reset_outputs", s),
          32'({in1_w[s], in2_w[s], busy_w[s], done_w[s], pass_w[s], tt_w[s]}), 32'd0);
    rst_n = 1'b1;
    tick();

    // directed table
    for (int i = 0; i < 11; i++) begin
      run_sweep(vecs[i].sel, vecs[i].gate, 4'b0000, vecs[i].expv, vecs[i].abort_at,
                vecs[i].restart_at, vecs[i].exp_chg, tt_a, pass_a);
      chk($sformatf("vec%0d_tt", i), 32'(tt_a), 32'(vecs[i].tt_exp));
      chk($sformatf("vec%0d_pass", i), 32'(pass_a), 32'(vecs[i].pass_exp));
    end

    // abort and start together in IDLE: start ignored, nothing changes
    tt_prev = tt_w[0];
    abort_r[0] = 1'b1;
    start_r[0] = 1'b1;
    tick();
    abort_r[0] = 1'b0;
    start_r[0] = 1'b0;
    chk("idle_abort_start_busy", 32'(busy_w[0]), 32'd0);
    tick();
    chk("idle_abort_start_busy2", 32'(busy_w[0]), 32'd0);
    chk("idle_abort_start_tt", 32'(tt_w[0]), 32'(tt_prev));
    chk("idle_abort_start_pass", 32'(pass_w[0]), 32'd1);

    // reset mid-sweep: outputs clear without waiting for an edge, no done
    for (int s = 0; s < 2; s++) begin
      gcode[s] = G_OR;
      exp_r[s] = 4'b1110;
      start_r[s] = 1'b1;
    end
    tick();
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++)
      chk($sformatf("s%0d_async_reset_outputs", s),
          32'({in1_w[s], in2_w[s], busy_w[s], done_w[s], pass_w[s], tt_w[s]}), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("reset_hold_c%0d_busy_done", c),
          32'({busy_w, done_w}), 32'd0);
    end
    rst_n = 1'b1;
    run_sweep(0, G_OR, 4'b0000, 4'b1110, 0, 0, 1'b0, tt_a, pass_a);
    chk("post_reset_s0_tt", 32'(tt_a), 32'(4'b1110));
    chk("post_reset_s0_pass", 32'(pass_a), 32'd1);
    run_sweep(1, G_OR, 4'b0000, 4'b1110, 0, 0, 1'b0, tt_a, pass_a);
    chk("post_reset_s1_tt", 32'(tt_a), 32'(4'b1110));

    // randomized sweeps against a vector-level reference
    for (int n = 0; n < 40; n++) begin
      int s, d, gate, ab, rs;
      logic [3:0] tbl, expv, tt_m;
      logic [1:0] vv;
      bit chg, aborted;
      s    = int'($urandom_range(0, 1));
      d    = dwell_of(s);
      gate = int'($urandom_range(0, 4));
      tbl  = 4'($urandom);
      chg  = 1'($urandom);
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4*d + 1)) : 0;
      rs   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4*d + 1)) : 0;
      aborted = (ab != 0) && (ab <= 4*d);
      if (aborted && rs > ab) rs = 0;
      for (int v = 0; v < 4; v++) begin
        vv = 2'(v);
        tt_m[v] = gate_fn(gate, vv[1], vv[0], tbl);
        if (aborted && (v + 1) * d >= ab) tt_m[v] = 1'b0;
      end
      expv = ($urandom_range(0, 1) == 0) ? tt_m : 4'($urandom);
      run_sweep(s, gate, tbl, expv, ab, rs, chg, tt_a, pass_a);
      chk($sformatf("rand%0d_tt", n), 32'(tt_a), 32'(tt_m));
      chk($sformatf("rand%0d_pass", n), 32'(pass_a), 32'(!aborted && (tt_m == expv)));
      for (int w = int'($urandom_range(0, 2)); w > 0; w--) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 Parameter DWELL, default 2: number of clock cycles each input vector is held on the gate before its output is sampled; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a sweep; accepted only in IDLE.
REQ-005 abort  input  1  cancel a sweep in progress.
REQ-006 expected  input  4  expected truth table; bit i = gate output for vector {in1,in2}=i.
REQ-007 in1  output  1  gate input A, driven from vector bit 1.
REQ-008 in2  output  1  gate input B, driven from vector bit 0.
REQ-009 gate_out  input  1  output of the 2-input gate under control (combinational from in1/in2).
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse at sweep completion.
REQ-012 tt  output  4  captured truth table; bit i = sampled gate_out for vector i.
REQ-013 pass  output  1  tt equals latched expected; valid from the done cycle until the next start.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, DRIVE, DONE.
REQ-015 IDLE: in1=in2=0, busy=0; start=1 latches expected, clears tt and pass, sets vec=0 and dwell count=0, and moves to DRIVE.
REQ-016 DRIVE: busy=1; in1/in2 SHALL equal vec bits 1/0 for every cycle of that vector, including the cycle in which gate_out is sampled.
REQ-017 Vector order SHALL be 00, 01, 10, 11; each vector is held exactly DWELL cycles.
REQ-018 On the DWELL-th cycle of a vector, gate_out SHALL be written to tt[vec] at the closing clock edge; the dwell count resets and vec increments; after vec=3 the FSM moves to DONE.
REQ-019 DONE lasts one cycle: done=1, busy=0, in1=in2=0, pass=(tt==latched expected); the FSM then returns to IDLE.
REQ-020 Latency: done SHALL assert exactly 4*DWELL+1 cycles after the edge that samples start.
REQ-021 start while busy, or in the DONE cycle, SHALL be ignored with no side effects.
REQ-022 abort in DRIVE SHALL return the FSM to IDLE at the next edge: no done pulse, pass=0, tt keeps the bits captured so far, in1=in2=0.
REQ-023 abort in IDLE or DONE SHALL have no effect; abort and start both high in IDLE: abort wins and start is ignored.
REQ-024 Changes on expected during a sweep SHALL NOT affect pass.
REQ-025 The dwell counter SHALL be 8 bits wide and SHALL never wrap within a vector.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, vec=0, dwell count=0, and in1, in2, busy, done, tt, pass, latched expected all to 0.
REQ-027 Reset asserted mid-sweep SHALL abandon the sweep without a done pulse; after release the block SHALL accept start on the first active edge.

Structure
REQ-028 State encodings (IDLE/DRIVE/DONE) and the vector count (4) SHALL live in the shared gate-library definitions include file.
REQ-029 The gate under control SHALL remain external (e.g. or_gate) and be wired through in1/in2/gate_out; there is no internal gate instance.
REQ-030 One sub-module, dwell_counter (load, enable, terminal-count flag), is natural; everything else is the FSM in gate_sweep_ctrl.

Verification
REQ-031 OR gate attached, DWELL=2, expected=4'b1110, start pulse -> done 9 cycles later, tt=4'b1110, pass=1.
REQ-032 AND gate attached, DWELL=1, expected=4'b1110 -> done 5 cycles after start, tt=4'b1000, pass=0.
REQ-033 gate_out tied to 0, expected=4'b1110 -> tt=4'b0000, pass=0; in1/in2 trace shows 00,01,10,11, each held DWELL cycles.
REQ-034 Second start pulse 3 cycles into a sweep -> ignored; exactly one done, at the original 4*DWELL+1 point.
REQ-035 abort in the 2nd vector (OR gate, DWELL=2) -> IDLE next cycle, no done, pass=0, tt=4'b0000; a subsequent start completes a normal sweep.
REQ-036 rst_n pulsed low mid-sweep -> all outputs 0 asynchronously, no done; a fresh sweep after release gives tt=4'b1110 with an OR gate.
